// File: rtl/layer3_argmax.sv
// Final classification stage: captures the layer-3 score vector and scans it
// one element per clock to find the index and value of the largest signed score.
module layer3_argmax #(
    parameter int NUM_CLASSES = 16,
    parameter int WIDTH       = 16,
    parameter int IDX_W       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CLASSES*WIDTH-1:0] N_flat,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             class_idx,
    output logic [WIDTH-1:0]             class_score,
    output logic                         all_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLASSES - 1);
    localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};

    state_t                         r_state,       w_state_nx;
    logic [NUM_CLASSES*WIDTH-1:0]   r_cap,         w_cap_nx;
    logic [IDX_W-1:0]               r_ptr,         w_ptr_nx;
    logic [WIDTH-1:0]               r_best_val,    w_best_val_nx;
    logic [IDX_W-1:0]               r_best_idx,    w_best_idx_nx;
    logic                           r_nz,          w_nz_nx;
    logic                           r_out_valid,   w_out_valid_nx;
    logic [IDX_W-1:0]               r_class_idx,   w_class_idx_nx;
    logic [WIDTH-1:0]               r_class_score, w_class_score_nx;
    logic                           r_all_zero,    w_all_zero_nx;

    logic [WIDTH-1:0]               w_elem;
    logic [WIDTH-1:0]               w_elem0;
    logic                           w_elem_gt;
    logic                           w_elem_pos;
    logic [WIDTH-1:0]               w_scan_val;
    logic [IDX_W-1:0]               w_scan_idx;
    logic                           w_scan_nz;

    assign w_elem     = r_cap[r_ptr*WIDTH +: WIDTH];
    assign w_elem0    = N_flat[WIDTH-1:0];
    assign w_elem_gt  = $signed(w_elem) > $signed(r_best_val);
    assign w_elem_pos = $signed(w_elem) > $signed(VAL_ZERO);

    // Running best after folding in the current element; strict compare keeps the lower index on ties.
    always_comb begin
        w_scan_val = r_best_val;
        w_scan_idx = r_best_idx;
        w_scan_nz  = r_nz | w_elem_pos;
        if (w_elem_gt) begin
            w_scan_val = w_elem;
            w_scan_idx = r_ptr;
        end else begin
            w_scan_val = r_best_val;
            w_scan_idx = r_best_idx;
        end
    end

    // Next-state and datapath update for the capture/scan/present sequence.
    always_comb begin
        w_state_nx       = r_state;
        w_cap_nx         = r_cap;
        w_ptr_nx         = r_ptr;
        w_best_val_nx    = r_best_val;
        w_best_idx_nx    = r_best_idx;
        w_nz_nx          = r_nz;
        w_out_valid_nx   = r_out_valid;
        w_class_idx_nx   = r_class_idx;
        w_class_score_nx = r_class_score;
        w_all_zero_nx    = r_all_zero;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nx    = ST_SCAN;
                    w_cap_nx      = N_flat;
                    w_best_val_nx = w_elem0;
                    w_best_idx_nx = {IDX_W{1'b0}};
                    w_ptr_nx      = IDX_ONE;
                    w_nz_nx       = $signed(w_elem0) > $signed(VAL_ZERO);
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SCAN: begin
                w_best_val_nx = w_scan_val;
                w_best_idx_nx = w_scan_idx;
                w_nz_nx       = w_scan_nz;
                if (r_ptr == IDX_LAST) begin
                    w_state_nx       = ST_DONE;
                    w_out_valid_nx   = 1'b1;
                    w_class_idx_nx   = w_scan_idx;
                    w_class_score_nx = w_scan_val;
                    w_all_zero_nx    = ~w_scan_nz;
                end else begin
                    w_ptr_nx = r_ptr + IDX_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nx     = ST_IDLE;
                    w_out_valid_nx = 1'b0;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: begin
                w_state_nx     = ST_IDLE;
                w_out_valid_nx = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any scan in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cap         <= {(NUM_CLASSES*WIDTH){1'b0}};
            r_ptr         <= {IDX_W{1'b0}};
            r_best_val    <= {WIDTH{1'b0}};
            r_best_idx    <= {IDX_W{1'b0}};
            r_nz          <= 1'b0;
            r_out_valid   <= 1'b0;
            r_class_idx   <= {IDX_W{1'b0}};
            r_class_score <= {WIDTH{1'b0}};
            r_all_zero    <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_cap         <= w_cap_nx;
            r_ptr         <= w_ptr_nx;
            r_best_val    <= w_best_val_nx;
            r_best_idx    <= w_best_idx_nx;
            r_nz          <= w_nz_nx;
            r_out_valid   <= w_out_valid_nx;
            r_class_idx   <= w_class_idx_nx;
            r_class_score <= w_class_score_nx;
            r_all_zero    <= w_all_zero_nx;
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = r_out_valid;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;
    assign all_zero    = r_all_zero;

endmodule

// File: tb/tb_layer3_argmax.sv
// Randomized and directed bench for layer3_argmax against a plain argmax model.
module tb_layer3_argmax;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] N_flat = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [IW-1:0]  class_idx;
    logic [W-1:0]   class_score;
    logic           all_zero;

    int errors = 0;
    int checks = 0;

    logic [W-1:0]  vals[N];
    logic [IW-1:0] m_idx;
    logic [W-1:0]  m_score;
    logic          m_az;

    layer3_argmax #(.NUM_CLASSES(N), .WIDTH(W), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .N_flat(N_flat), .out_valid(out_valid), .out_ready(out_ready),
        .class_idx(class_idx), .class_score(class_score), .all_zero(all_zero)
    );

    always #5 clk = ~clk;

    // Reference: first index of the signed maximum; all_zero when nothing is positive.
    function automatic void model();
        m_idx = '0;
        m_score = vals[0];
        m_az = 1'b1;
        for (int i = 0; i < N; i++) begin
            if ($signed(vals[i]) > $signed(m_score)) begin
                m_score = vals[i];
                m_idx = IW'(i);
            end
            if ($signed(vals[i]) > 16'sd0) m_az = 1'b0;
        end
    endfunction

    task automatic drive_vals();
        for (int i = 0; i < N; i++) N_flat[i*W +: W] = vals[i];
    endtask

    task automatic scramble_bus();
        for (int i = 0; i < N; i++) N_flat[i*W +: W] = W'($urandom);
    endtask

    // Present vals, wait for the result, check latency and outputs; optionally complete the handshake.
    task automatic send(input string name, input bit release_now);
        int edges;
        model();
        @(negedge clk);
        drive_vals();
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready_idle got=%b exp=1", name, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_bus();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_scan got=%b exp=0", name, in_ready); end
        edges = 1;
        while (out_valid !== 1'b1 && edges < 40) begin
            checks++;
            if (edges > 1 && in_ready !== 1'b0) begin errors++; $display("FAIL %s in_ready_busy got=%b exp=0", name, in_ready); end
            @(posedge clk); #1;
            edges++;
        end
        edges = edges - 1;
        checks++;
        if (edges != 15) begin errors++; $display("FAIL %s latency got=%0d exp=15", name, edges); end
        checks++;
        if (class_idx !== m_idx) begin errors++; $display("FAIL %s class_idx got=%0d exp=%0d", name, class_idx, m_idx); end
        checks++;
        if (class_score !== m_score) begin errors++; $display("FAIL %s class_score got=%h exp=%h", name, class_score, m_score); end
        checks++;
        if (all_zero !== m_az) begin errors++; $display("FAIL %s all_zero got=%b exp=%b", name, all_zero, m_az); end
        if (release_now) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL %s release got out_valid=%b in_ready=%b exp 0/1", name, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || class_idx !== 4'd0 || class_score !== 16'd0 || all_zero !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got v=%b idx=%0d score=%h az=%b exp 0/0/0/0", out_valid, class_idx, class_score, all_zero);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        for (int i = 0; i < N; i++) vals[i] = W'(10 * i);
        send("ramp", 1'b1);
        for (int i = 0; i < N; i++) vals[i] = 16'h0000;
        send("zeros", 1'b1);
        for (int i = 0; i < N; i++) vals[i] = 16'h0010;
        vals[3] = 16'h0200; vals[9] = 16'h0200;
        send("tie", 1'b1);
        for (int i = 0; i < N; i++) vals[i] = 16'h0000;
        vals[0] = 16'h8000; vals[5] = 16'h0001;
        send("signed", 1'b1);
        for (int i = 0; i < N; i++) vals[i] = 16'h8000 + W'(i);
        send("all_negative", 1'b1);
    endtask

    task automatic test_random();
        logic [W-1:0] pick[5];
        for (int t = 0; t < 25; t++) begin
            pick[0] = 16'h0000; pick[1] = 16'h7FFF; pick[2] = 16'h8000;
            pick[3] = W'($urandom_range(0, 40)); pick[4] = W'($urandom);
            for (int i = 0; i < N; i++) vals[i] = pick[$urandom_range(0, 4)];
            send("random", 1'b1);
        end
    endtask

    task automatic test_stall();
        logic [IW-1:0] a_idx;
        logic [W-1:0]  a_score;
        logic [W-1:0]  b_vals[N];
        int edges;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) vals[i] = W'($urandom_range(0, 1000));
        send("stall_a", 1'b0);
        a_idx = m_idx; a_score = m_score;
        for (int i = 0; i < N; i++) b_vals[i] = W'($urandom_range(0, 1000));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (c == 4) begin
                for (int i = 0; i < N; i++) N_flat[i*W +: W] = b_vals[i];
                in_valid = 1'b1;
            end
            checks++;
            if (out_valid !== 1'b1 || class_idx !== a_idx || class_score !== a_score || in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold got v=%b idx=%0d score=%h rdy=%b exp 1/%0d/%h/0", out_valid, class_idx, class_score, in_ready, a_idx, a_score);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release got v=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_bus();
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_accept in_ready got=%b exp=0", in_ready); end
        for (int i = 0; i < N; i++) vals[i] = b_vals[i];
        model();
        edges = 0;
        while (out_valid !== 1'b1 && edges < 40) begin @(posedge clk); #1; edges++; end
        checks++;
        if (edges != 15) begin errors++; $display("FAIL stall_b latency got=%0d exp=15", edges); end
        checks++;
        if (class_idx !== m_idx || class_score !== m_score || all_zero !== m_az) begin
            errors++; $display("FAIL stall_b result got idx=%0d score=%h az=%b exp %0d/%h/%b", class_idx, class_score, all_zero, m_idx, m_score, m_az);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        for (int i = 0; i < N; i++) vals[i] = 16'h0001;
        vals[2] = 16'h7000;
        @(negedge clk);
        drive_vals();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || class_idx !== 4'd0 || class_score !== 16'd0) begin
            errors++; $display("FAIL abort_reset got v=%b rdy=%b idx=%0d score=%h exp 0/1/0/0", out_valid, in_ready, class_idx, class_score);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < N; i++) vals[i] = W'(100 - i);
        vals[11] = 16'h0300;
        send("after_abort", 1'b1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
